// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - program-run sequencer: req/done handshake, core reset window, run budget
//
// Purpose
//    Handles one program run of the core. On a host request it holds the core
//    in reset for RST_CYCLES cycles. It then enables the core and counts the
//    enabled cycles. The run ends when the core reports its terminal PC
//    (i_core_done), when the cycle budget TIMEOUT is used up, or when the host
//    aborts the run by dropping i_req.
//
// Optional feature
//    SEQ_SINGLE_STEP_EN : in RUN, the core is enabled for a single cycle on
//                         each rising edge of i_step. Only those stepped
//                         cycles are counted.
//
// Ports
//    i_clk        in   1   system clock, all state on posedge
//    i_reset      in   1   asynchronous active-low reset
//    i_req        in   1   run request level, held high for the whole run
//    i_core_done  in   1   core terminal-PC flag, evaluated only in RUN
//    i_step       in   1   single-step strobe (SEQ_SINGLE_STEP_EN only)
//    o_core_rst   out  1   active-high reset to the core
//    o_core_en    out  1   core clock enable
//    o_busy       out  1   high in RST and RUN
//    o_done       out  1   high in DONE and FAULT
//    o_timeout    out  1   high in FAULT
//    o_cycle_cnt  out  CW  enabled RUN cycles in the current or last run
module run_sequencer #(
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned CW         = 16,
   parameter int unsigned TIMEOUT    = 32'h0000_FFFF
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_req,
   input  logic          i_core_done,
   input  logic          i_step,
   output logic          o_core_rst,
   output logic          o_core_en,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_timeout,
   output logic [CW-1:0] o_cycle_cnt
);

   localparam int unsigned   RW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RST_LOAD  = RW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] BUDGET    = CW'(TIMEOUT);
   localparam bit            BUDGET_ON = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RST   = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [RW-1:0] r_rst_cnt;
   logic [RW-1:0] w_rst_cnt_nxt;
   logic [CW-1:0] r_cycle_cnt;
   logic [CW-1:0] w_cycle_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_run_en;

`ifdef SEQ_SINGLE_STEP_EN
   // r_step_q holds i_step from the last edge, and r_step_d holds the value one
   // edge before that. A rise sampled at edge k makes r_step_q=1 and r_step_d=0
   // for exactly the cycle that follows edge k.
   logic r_step_q;
   logic r_step_d;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_step_q <= 1'b0;
         r_step_d <= 1'b0;
      end else begin
         r_step_q <= i_step;
         r_step_d <= r_step_q;
      end
   end

   assign w_run_en = (r_state == S_RUN) && r_step_q && !r_step_d;
`else
   logic w_unused_step;
   assign w_unused_step = i_step;
   assign w_run_en      = (r_state == S_RUN);
`endif

   // The counter saturates instead of wrapping, so a long run with the budget
   // disabled still reports a meaningful (pinned) cycle count.
   assign w_cnt_inc = (r_cycle_cnt == CNT_MAX) ? r_cycle_cnt : r_cycle_cnt + CW'(1);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_rst_cnt   <= '0;
         r_cycle_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rst_cnt   <= w_rst_cnt_nxt;
         r_cycle_cnt <= w_cycle_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rst_cnt_nxt   = r_rst_cnt;
      w_cycle_cnt_nxt = r_cycle_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_req) begin
               w_state_nxt     = S_RST;
               w_rst_cnt_nxt   = RST_LOAD;
               w_cycle_cnt_nxt = '0;
            end
         end
         S_RST: begin
            if (r_rst_cnt == '0) w_state_nxt = S_RUN;
            else                 w_rst_cnt_nxt = r_rst_cnt - RW'(1);
         end
         S_RUN: begin
            // The cycle that ends the run is still counted, whatever the reason
            // for ending it (abort, core_done or budget).
            if (w_run_en) w_cycle_cnt_nxt = w_cnt_inc;
            if (!i_req)                                       w_state_nxt = S_IDLE;
            else if (i_core_done)                             w_state_nxt = S_DONE;
            else if (BUDGET_ON && w_run_en && (w_cnt_inc == BUDGET)) w_state_nxt = S_FAULT;
         end
         S_DONE, S_FAULT: begin
            if (!i_req) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_core_rst = 1'b0;
      o_core_en  = 1'b0;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      o_timeout  = 1'b0;
      case (r_state)
         S_IDLE: o_core_rst = 1'b1;
         S_RST: begin
            o_core_rst = 1'b1;
            o_busy     = 1'b1;
         end
         S_RUN: begin
            o_core_en = w_run_en;
            o_busy    = 1'b1;
         end
         S_DONE: o_done = 1'b1;
         S_FAULT: begin
            o_done    = 1'b1;
            o_timeout = 1'b1;
         end
         default: o_core_rst = 1'b1;
      endcase
   end

   assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed self-checking bench for run_sequencer
module tb_run_sequencer;

   logic        clk;
   logic        reset;
   logic        req;
   logic        core_done;
   logic        step;
   logic        core_rst;
   logic        core_en;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] cycle_cnt;

   logic        req2;
   logic        core_done2;
   logic        s_core_rst;
   logic        s_core_en;
   logic        s_busy;
   logic        s_done;
   logic        s_timeout;
   logic [3:0]  s_cycle_cnt;

   int checks = 0;
   int errors = 0;

   run_sequencer #(.RST_CYCLES(2), .CW(16), .TIMEOUT(20)) u_dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_req       (req),
      .i_core_done (core_done),
      .i_step      (step),
      .o_core_rst  (core_rst),
      .o_core_en   (core_en),
      .o_busy      (busy),
      .o_done      (done),
      .o_timeout   (timeout),
      .o_cycle_cnt (cycle_cnt)
   );

   run_sequencer #(.RST_CYCLES(1), .CW(4), .TIMEOUT(0)) u_sat (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_req       (req2),
      .i_core_done (core_done2),
      .i_step      (step),
      .o_core_rst  (s_core_rst),
      .o_core_en   (s_core_en),
      .o_busy      (s_busy),
      .o_done      (s_done),
      .o_timeout   (s_timeout),
      .o_cycle_cnt (s_cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 1'b0; core_done = 1'b0; step = 1'b0;
      req2 = 1'b0; core_done2 = 1'b0;
      #2;
      checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %0b exp 1", core_rst); end
      checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en got %0b exp 0", core_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b exp 0", timeout); end
      checks++; if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cycle_cnt got %0d exp 0", cycle_cnt); end
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++; if (core_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle got rst=%0b busy=%0b exp rst=1 busy=0", core_rst, busy); end
   endtask

   task automatic test_run_done();
      int en_cycles = 0;
      req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (core_rst !== 1'b1 || busy !== 1'b1 || core_en !== 1'b0) begin errors++; $display("FAIL run_rst_window%0d got rst=%0b busy=%0b en=%0b exp 1 1 0", i, core_rst, busy, core_en); end
      end
      tick();
      for (int i = 1; i <= 10; i++) begin
         if (core_en === 1'b1 && core_rst === 1'b0) en_cycles++;
         if (i == 10) core_done = 1'b1;
         tick();
      end
      core_done = 1'b0;
      checks++; if (en_cycles != 10) begin errors++; $display("FAIL run_en_cycles got %0d exp 10", en_cycles); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done got %0b exp 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy got %0b exp 0", busy); end
      checks++; if (cycle_cnt !== 16'd10) begin errors++; $display("FAIL run_cycle_cnt got %0d exp 10", cycle_cnt); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL run_timeout got %0b exp 0", timeout); end
      checks++; if (core_en !== 1'b0 || core_rst !== 1'b0) begin errors++; $display("FAIL run_done_frozen got en=%0b rst=%0b exp 0 0", core_en, core_rst); end
   endtask

   task automatic test_hold_req();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL hold_done%0d got done=%0b busy=%0b exp 1 0", i, done, busy); end
      end
      req = 1'b0;
      tick();
      checks++; if (done !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL hold_release got done=%0b rst=%0b exp 0 1", done, core_rst); end
      checks++; if (cycle_cnt !== 16'd10) begin errors++; $display("FAIL hold_cnt_kept got %0d exp 10", cycle_cnt); end
   endtask

   task automatic test_timeout();
      req = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 1; i <= 20; i++) begin
         checks++; if (core_en !== 1'b1 || cycle_cnt !== 16'(i - 1)) begin errors++; $display("FAIL budget_run%0d got en=%0b cnt=%0d exp en=1 cnt=%0d", i, core_en, cycle_cnt, i - 1); end
         tick();
      end
      checks++; if (done !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL budget_fault got done=%0b timeout=%0b exp 1 1", done, timeout); end
      checks++; if (cycle_cnt !== 16'd20) begin errors++; $display("FAIL budget_cnt got %0d exp 20", cycle_cnt); end
      checks++; if (core_en !== 1'b0 || core_rst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL budget_outputs got en=%0b rst=%0b busy=%0b exp 0 0 0", core_en, core_rst, busy); end
      req = 1'b0;
      tick();
      checks++; if (done !== 1'b0 || timeout !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL budget_release got done=%0b timeout=%0b rst=%0b exp 0 0 1", done, timeout, core_rst); end
   endtask

   task automatic test_abort();
      int done_seen = 0;
      req = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 1; i <= 5; i++) begin
         if (done === 1'b1) done_seen++;
         if (i == 5) req = 1'b0;
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) done_seen++;
         tick();
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_seen); end
      checks++; if (cycle_cnt !== 16'd5) begin errors++; $display("FAIL abort_cnt got %0d exp 5", cycle_cnt); end
      checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || core_en !== 1'b0) begin errors++; $display("FAIL abort_idle got rst=%0b busy=%0b en=%0b exp 1 0 0", core_rst, busy, core_en); end
   endtask

   task automatic test_ignored_inputs();
      core_done = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      core_done = 1'b0;
      checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignored_idle got rst=%0b busy=%0b done=%0b exp 1 0 0", core_rst, busy, done); end
   endtask

   task automatic test_async_reset();
      req = 1'b1;
      tick();
      tick();
      tick();
      tick();
      tick();
      checks++; if (core_en !== 1'b1 || cycle_cnt !== 16'd2) begin errors++; $display("FAIL areset_pre got en=%0b cnt=%0d exp 1 2", core_en, cycle_cnt); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (core_rst !== 1'b1 || core_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_outputs got rst=%0b en=%0b busy=%0b exp 1 0 0", core_rst, core_en, busy); end
      checks++; if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", cycle_cnt); end
      req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      checks++; if (core_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL areset_idle got rst=%0b busy=%0b exp 1 0", core_rst, busy); end
   endtask

`ifdef SEQ_SINGLE_STEP_EN
   task automatic test_single_step();
      int en_cycles = 0;
      int en_pairs  = 0;
      logic prev_en = 1'b0;
      req = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 1; i <= 16; i++) begin
         if (core_en === 1'b1) en_cycles++;
         if (core_en === 1'b1 && prev_en === 1'b1) en_pairs++;
         prev_en = core_en;
         step = (i == 2 || i == 6 || i == 10) ? 1'b1 : 1'b0;
         tick();
      end
      step = 1'b0;
      checks++; if (en_cycles != 3) begin errors++; $display("FAIL step_en_cycles got %0d exp 3", en_cycles); end
      checks++; if (en_pairs != 0) begin errors++; $display("FAIL step_single got %0d exp 0", en_pairs); end
      checks++; if (cycle_cnt !== 16'd3 || busy !== 1'b1) begin errors++; $display("FAIL step_cnt got cnt=%0d busy=%0b exp 3 1", cycle_cnt, busy); end
      req = 1'b0;
      tick();
   endtask
`else
   task automatic test_step_unused();
      int en_cycles = 0;
      req = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 1; i <= 8; i++) begin
         if (core_en === 1'b1) en_cycles++;
         step = i[0];
         tick();
      end
      step = 1'b0;
      checks++; if (en_cycles != 8 || cycle_cnt !== 16'd8) begin errors++; $display("FAIL step_unused got en=%0d cnt=%0d exp 8 8", en_cycles, cycle_cnt); end
      req = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      req2 = 1'b1;
      tick();
      checks++; if (s_core_rst !== 1'b1 || s_busy !== 1'b1) begin errors++; $display("FAIL sat_rst1 got rst=%0b busy=%0b exp 1 1", s_core_rst, s_busy); end
      tick();
      checks++; if (s_core_en !== 1'b1 || s_core_rst !== 1'b0) begin errors++; $display("FAIL sat_latency got en=%0b rst=%0b exp 1 0", s_core_en, s_core_rst); end
      for (int i = 0; i < 20; i++) tick();
      checks++; if (s_cycle_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", s_cycle_cnt); end
      checks++; if (s_busy !== 1'b1 || s_timeout !== 1'b0) begin errors++; $display("FAIL sat_no_budget got busy=%0b timeout=%0b exp 1 0", s_busy, s_timeout); end
      core_done2 = 1'b1;
      tick();
      core_done2 = 1'b0;
      checks++; if (s_done !== 1'b1 || s_cycle_cnt !== 4'd15) begin errors++; $display("FAIL sat_done got done=%0b cnt=%0d exp 1 15", s_done, s_cycle_cnt); end
      req2 = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_run_done();
      test_hold_req();
      test_timeout();
      test_abort();
      test_ignored_inputs();
      test_async_reset();
`ifdef SEQ_SINGLE_STEP_EN
      test_single_step();
`else
      test_step_unused();
      test_saturation();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
